mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Access size encodings (2'b11 behaves as a word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Index of the final byte of an access (nbytes - 1).
  function automatic logic [1:0] size_last(input logic [1:0] sz);
    logic [1:0] v;
    case (sz)
      SZ_BYTE: v = 2'd0;
      SZ_HALF: v = 2'd1;
      default: v = 2'd3;
    endcase
    return v;
  endfunction

  // Zero- or sign-fill the bytes above the last one loaded.
  function automatic logic [31:0] load_fill(input logic [31:0] raw, input logic [1:0] sz,
                                            input logic sx);
    logic [31:0] v;
    case (sz)
      SZ_BYTE: v = {{24{sx & raw[7]}}, raw[7:0]};
      SZ_HALF: v = {{16{sx & raw[15]}}, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: fixed priority from port 0, or round-robin
// starting just after the last granted port.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_rr,
  output logic [N_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan candidates in priority order and take the first one requesting.
  always_comb begin
    int   base;
    int   cand;
    logic found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    base  = i_rr ? int'(i_ptr) + 1 : 0;
    cand  = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = base + i;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      for (int p = 0; p < N_PORTS; p++) begin
        if (!found && p == cand && i_req[p]) begin
          o_gnt[p] = 1'b1;
          o_idx    = IDX_W'(p);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port arbiter onto a byte-wide RAM. Each granted access is split into
// 1/2/4 byte beats; reads take RAM_LAT cycles per byte and may be cancelled.
//
// state | meaning
// IDLE  | arbitrate; on a grant latch the port's fields and start beat 0
// XFER  | stream bytes to/from RAM; reads may be cancelled here
// DONE  | one-cycle completion pulse on the granted port, no arbitration
module mem_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 2,
  parameter int RR_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS-1:0]        we,
  input  logic [2*N_PORTS-1:0]      size,
  input  logic [N_PORTS-1:0]        sext,
  input  logic [ADDR_W*N_PORTS-1:0] addr,
  input  logic [32*N_PORTS-1:0]     wdata,
  input  logic [N_PORTS-1:0]        cancel,
  output logic [N_PORTS-1:0]        done,
  output logic [32*N_PORTS-1:0]     rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata
);
  import mem_arbiter_pkg::*;

  localparam int               IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [1:0]       LAT_LD  = 2'(RAM_LAT - 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_PORTS - 1);
  localparam logic             RR_EN   = (RR_MODE != 0);

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [N_PORTS-1:0]    r_gnt_oh;
  logic                  r_we;
  logic [1:0]            r_size;
  logic [1:0]            r_last;
  logic                  r_sext;
  logic [31:0]           r_wdata;
  logic [1:0]            r_k;
  logic [1:0]            r_lat;
  logic [31:0]           r_buf;
  logic [N_PORTS-1:0]    r_done;
  logic [32*N_PORTS-1:0] r_rdata;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_mem_wr;
  logic [7:0]            r_mem_wdata;

  logic [N_PORTS-1:0]    w_gnt_oh;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_sel_we;
  logic [1:0]            w_sel_size;
  logic                  w_sel_sext;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic                  w_cancel;
  logic [31:0]           w_raw;
  logic [7:0]            w_next_wbyte;
  logic [31:0]           w_load;

  mem_arb_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .i_rr  (RR_EN),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx)
  );

  // Mux the candidate port's request fields using the one-hot grant.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_size  = '0;
    w_sel_sext  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_gnt_oh[p]) begin
        w_sel_we    = we[p];
        w_sel_size  = size[2*p +: 2];
        w_sel_sext  = sext[p];
        w_sel_addr  = addr[ADDR_W*p +: ADDR_W];
        w_sel_wdata = wdata[32*p +: 32];
      end
    end
  end

  assign w_cancel = |(cancel & r_gnt_oh);
  assign w_load   = load_fill(w_raw, r_size, r_sext);

  // Merge the byte arriving this cycle into the partial load word.
  always_comb begin
    w_raw = r_buf;
    case (r_k)
      2'd0:    w_raw[7:0]   = mem_rdata;
      2'd1:    w_raw[15:8]  = mem_rdata;
      2'd2:    w_raw[23:16] = mem_rdata;
      default: w_raw[31:24] = mem_rdata;
    endcase
  end

  // Store byte for the beat following the current one.
  always_comb begin
    case (r_k)
      2'd0:    w_next_wbyte = r_wdata[15:8];
      2'd1:    w_next_wbyte = r_wdata[23:16];
      default: w_next_wbyte = r_wdata[31:24];
    endcase
  end

  // Main sequencer: arbitration, byte beats, read capture and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= PTR_RST;
      r_gnt_oh    <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_last      <= 2'd0;
      r_sext      <= 1'b0;
      r_wdata     <= '0;
      r_k         <= 2'd0;
      r_lat       <= 2'd0;
      r_buf       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= '0;
          if (|req) begin
            r_state     <= ST_XFER;
            r_gnt_oh    <= w_gnt_oh;
            r_ptr       <= w_gnt_idx;
            r_we        <= w_sel_we;
            r_size      <= w_sel_size;
            r_last      <= size_last(w_sel_size);
            r_sext      <= w_sel_sext;
            r_wdata     <= w_sel_wdata;
            r_k         <= 2'd0;
            r_lat       <= LAT_LD;
            r_buf       <= '0;
            r_mem_addr  <= w_sel_addr;
            r_mem_wr    <= w_sel_we;
            r_mem_wdata <= w_sel_wdata[7:0];
          end
        end
        ST_XFER: begin
          if (r_we) begin
            if (r_k == r_last) begin
              r_state  <= ST_DONE;
              r_done   <= r_gnt_oh;
              r_mem_wr <= 1'b0;
            end else begin
              r_k         <= r_k + 2'd1;
              r_mem_addr  <= r_mem_addr + ADDR_W'(1);
              r_mem_wdata <= w_next_wbyte;
            end
          end else if (w_cancel) begin
            r_state <= ST_IDLE;
          end else if (r_lat != 2'd0) begin
            r_lat <= r_lat - 2'd1;
          end else if (r_k == r_last) begin
            r_state <= ST_DONE;
            r_done  <= r_gnt_oh;
            for (int p = 0; p < N_PORTS; p++) begin
              if (r_gnt_oh[p]) r_rdata[32*p +: 32] <= w_load;
            end
          end else begin
            r_buf      <= w_raw;
            r_k        <= r_k + 2'd1;
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
            r_lat      <= LAT_LD;
          end
        end
        ST_DONE: begin
          r_done  <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done   <= '0;
          r_mem_wr <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share the
// same port stimulus; each drives its own byte RAM. A transaction-level model
// predicts beat addresses, write bytes, completion cycles and load values.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic [1:0]  req, we, sext, cancel;
  logic [3:0]  size;
  logic [63:0] addr, wdata;

  logic [1:0]  done_v  [2];
  logic [63:0] rdata_v [2];
  logic [31:0] maddr_v [2];
  logic        mwr_v   [2];
  logic [7:0]  mwd_v   [2];
  logic [7:0]  mrd_v   [2];

  logic [7:0]  ram     [2][256];
  logic [7:0]  ram_ref [256];
  logic [31:0] exp_rd  [2][2];

  int n_tests;
  int n_fail;

  mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .RAM_LAT(LAT), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .cancel(cancel), .done(done_v[0]), .rdata(rdata_v[0]),
    .mem_addr(maddr_v[0]), .mem_wr(mwr_v[0]), .mem_wdata(mwd_v[0]), .mem_rdata(mrd_v[0])
  );

  mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .RAM_LAT(LAT), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .cancel(cancel), .done(done_v[1]), .rdata(rdata_v[1]),
    .mem_addr(maddr_v[1]), .mem_wr(mwr_v[1]), .mem_wdata(mwd_v[1]), .mem_rdata(mrd_v[1])
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i + 1) * 17);
  endfunction

  // Byte RAMs behind each instance; contents return to the seed pattern on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        ram[0][i] <= init_byte(i);
        ram[1][i] <= init_byte(i);
      end
    end else begin
      for (int d = 0; d < 2; d++)
        if (mwr_v[d]) ram[d][maddr_v[d][7:0]] <= mwd_v[d];
    end
  end

  assign mrd_v[0] = ram[0][maddr_v[0][7:0]];
  assign mrd_v[1] = ram[1][maddr_v[1][7:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference load: gather bytes from the model RAM and extend.
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx);
    logic [31:0] v;
    int nb;
    nb = nbytes(sz);
    v  = 0;
    for (int k = 0; k < nb; k++) v = v | (32'(ram_ref[8'(a + 32'(k))]) << (8 * k));
    if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  function automatic int rr_next(input logic [1:0] rq, input int last);
    int j;
    for (int i = 1; i <= 2; i++) begin
      j = (last + i) % 2;
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [1:0] v);
    return v[1] ? 1 : 0;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 256; i++) ram_ref[i] = init_byte(i);
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) exp_rd[d][p] = 0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
    we[p]            = w;
    size[2*p +: 2]   = sz;
    sext[p]          = sx;
    addr[32*p +: 32] = a;
    wdata[32*p +: 32] = wd;
  endtask

  // One single-requester transaction, called at a negedge with both DUTs idle.
  // cc != 0 pulses cancel in that cycle (reads abort, writes ignore it).
  task automatic do_xfer(input int p, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input int cc);
    int nb, dcyc, last, bi;
    logic cxl;
    logic [31:0] ea, ev;
    nb   = nbytes(sz);
    dcyc = w ? nb + 1 : nb * LAT + 1;
    cxl  = !w && cc != 0;
    last = cxl ? cc + 1 : dcyc;
    set_port(p, w, sz, sx, a, wd);
    req[p] = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      bi = w ? c - 1 : (c - 1) / LAT;
      if (c == dcyc && !cxl) begin
        if (w) begin
          for (int k = 0; k < nb; k++) ram_ref[8'(a + 32'(k))] = wd[8*k +: 8];
        end else begin
          ev = model_read(a, sz, sx);
          exp_rd[0][p] = ev;
          exp_rd[1][p] = ev;
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (cxl && c == cc + 1) begin
          ea = a + 32'((cc - 1) / LAT);
          chk("cancel_addr_hold", maddr_v[d], ea);
        end else if (c < dcyc) begin
          ea = a + 32'(bi);
          chk("beat_addr", maddr_v[d], ea);
          chk("beat_wr", mwr_v[d], w);
          if (w) chk("beat_wdata", mwd_v[d], wd[8*bi +: 8]);
        end else begin
          chk("done_wr_low", mwr_v[d], 1'b0);
          chk("done_rdata", rdata_v[d][32*p +: 32], exp_rd[d][p]);
        end
        chk("done_pulse", done_v[d], (c == dcyc && !cxl) ? (2'b01 << p) : 2'b00);
      end
      if (c == cc) begin
        cancel[p] = 1'b1;
        if (cxl) req[p] = 1'b0;
      end
      if (c == cc + 1) cancel[p] = 1'b0;
      if (c == dcyc) req[p] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_done", done_v[d], 2'b00);
      chk("post_wr", mwr_v[d], 1'b0);
      chk("post_rdata", rdata_v[d][32*p +: 32], exp_rd[d][p]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, nb, cc, last_b, got_a, got_b, e;
    int qa[$];
    int qb[$];
    logic w, sx;
    logic [1:0] sz;
    logic [31:0] a, wd;

    n_tests = 0;
    n_fail  = 0;
    clk_run = 1'b0;
    rst     = 1'b1;
    req = '0; we = '0; sext = '0; cancel = '0; size = '0; addr = '0; wdata = '0;
    reset_model();

    // Asynchronous reset with the clock stopped
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_done", done_v[d], 2'b00);
      chk("rst_rdata", rdata_v[d], 64'd0);
      chk("rst_maddr", maddr_v[d], 32'd0);
      chk("rst_mwr", mwr_v[d], 1'b0);
      chk("rst_mwdata", mwd_v[d], 8'd0);
    end
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Word read at 0x100, RAM holds 11 22 33 44
    do_xfer(0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 0);
    chk("word_read_value", rdata_v[0][31:0], 32'h4433_2211);
    // Byte 0x80 with and without sign extension
    do_xfer(0, 1'b0, 2'b00, 1'b1, 32'h0000_007F, 32'd0, 0);
    chk("byte_sext", rdata_v[1][31:0], 32'hFFFF_FF80);
    do_xfer(0, 1'b0, 2'b00, 1'b0, 32'h0000_007F, 32'd0, 0);
    chk("byte_zext", rdata_v[0][31:0], 32'h0000_0080);
    // Half write across the top of the address space, then read it back
    do_xfer(1, 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, 0);
    chk("wrap_ram_ff", ram[0][255], 8'hEF);
    chk("wrap_ram_00", ram[1][0], 8'hBE);
    do_xfer(1, 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd0, 0);
    chk("wrap_readback", rdata_v[1][63:32], 32'h0000_BEEF);

    // Port0 word read cancelled in cycle 3 while port1 waits with a byte read
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
    set_port(1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'd0);
    req = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 7) begin
        exp_rd[0][1] = model_read(32'h10, 2'b00, 1'b0);
        exp_rd[1][1] = exp_rd[0][1];
      end
      for (int d = 0; d < 2; d++) begin
        chk("cxl_no_done0", done_v[d][0], 1'b0);
        chk("cxl_port1_done", done_v[d][1], c == 7);
        chk("cxl_rdata0_kept", rdata_v[d][31:0], exp_rd[d][0]);
      end
      if (c == 3) begin cancel[0] = 1'b1; req[0] = 1'b0; end
      if (c == 4) cancel[0] = 1'b0;
      if (c == 7) req[1] = 1'b0;
    end
    for (int d = 0; d < 2; d++) chk("cxl_rdata1", rdata_v[d][63:32], exp_rd[d][1]);

    // Both ports requesting continuously: grant order per arbitration mode
    set_port(0, 1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'd0);
    set_port(1, 1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'd0);
    req = 2'b11;
    for (int c = 0; c < 60 && !(qa.size() >= 4 && qb.size() >= 4); c++) begin
      @(negedge clk);
      if (done_v[0] != 2'b00) qa.push_back(oh_idx(done_v[0]));
      if (done_v[1] != 2'b00) qb.push_back(oh_idx(done_v[1]));
    end
    chk("contend_bound", (qa.size() >= 4) && (qb.size() >= 4), 1'b1);
    last_b = 1;
    for (int k = 0; k < 4; k++) begin
      e = rr_next(2'b11, last_b);
      chk("fp_order", (k < qa.size()) ? qa[k] : -1, 0);
      chk("rr_order", (k < qb.size()) ? qb[k] : -1, e);
      last_b = e;
    end
    req[0] = 1'b0;
    got_a = -1;
    got_b = -1;
    for (int c = 0; c < 20 && (got_a < 0 || got_b < 0); c++) begin
      @(negedge clk);
      if (got_a < 0 && done_v[0] != 2'b00) got_a = oh_idx(done_v[0]);
      if (got_b < 0 && done_v[1] != 2'b00) got_b = oh_idx(done_v[1]);
    end
    req[1] = 1'b0;
    chk("fp_after_drop", got_a, 1);
    chk("rr_after_drop", got_b, rr_next(2'b10, last_b));
    for (int d = 0; d < 2; d++) begin
      exp_rd[d][0] = model_read(32'h20, 2'b00, 1'b0);
      exp_rd[d][1] = model_read(32'h30, 2'b00, 1'b0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("contend_rdata0", rdata_v[d][31:0], exp_rd[d][0]);
      chk("contend_rdata1", rdata_v[d][63:32], exp_rd[d][1]);
    end

    // Reset in the middle of a write
    set_port(0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hA5A5_5A5A);
    req[0] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("midrst_wr_before", mwr_v[d], 1'b1);
    #2 rst = 1'b0;
    req = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_wr_drop", mwr_v[d], 1'b0);
      chk("midrst_rdata", rdata_v[d], 64'd0);
    end
    #1 rst = 1'b1;
    reset_model();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("midrst_no_done", done_v[d], 2'b00);
    end

    // Randomized single-port traffic, including wrap-around and cancels
    for (int t = 0; t < 40; t++) begin
      p  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      wd = $urandom;
      nb = nbytes(sz);
      cc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, w ? nb : nb * LAT)) : 0;
      do_xfer(p, w, sz, sx, a, wd, cc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
